sobel_threshold_ctrl: RTL and testbench

SOBEL_THRESHOLD_CTRL -- requirements
Module: sobel_threshold_ctrl

---
 rtl/sobel_threshold_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sobel_threshold_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_threshold_ctrl.sv
// ----------------------------------------------------------------------------
// sobel_threshold_ctrl
//
// Purpose:
//   Turns key presses into a 4-bit Sobel edge-detection grade and maps that
//   grade to an 8-bit threshold. The grade changes as soon as a key acts on
//   it. The threshold fed to the Sobel datapath only changes once per frame,
//   at the rising edge of per_frame_vsync, so a frame is never processed with
//   two different thresholds.
//
// Optional feature (macro SOBEL_AUTO_REPEAT_EN):
//   When the macro is defined, holding a decrement or increment key
//   auto-repeats. The first repeat comes HOLD_DLY cycles after the press and
//   later repeats come every RPT_PERIOD cycles. When the macro is not
//   defined, key_hold is ignored and only key_flag steps the grade.
//
// Key input protocol:
//   key_value is valid in any cycle where key_flag is high, and for as long as
//   key_hold stays high. key_flag is a one-cycle pulse per physical press.
//   There is no back-pressure: every press is taken in the cycle it arrives.
//
// Ports:
//   clk              in   system clock (100 MHz), the only clock
//   rst              in   synchronous active-high reset
//   key_flag         in   one-cycle pulse for a new key press
//   key_value[1:0]   in   01 decrement, 10 increment, 11 restore default, 00 none
//   key_hold         in   level, high while the key is held down
//   per_frame_vsync  in   frame sync, high during vertical blank
//   sobel_grade[3:0] out  pending grade, follows key actions immediately
//   sobel_threshold  out  active threshold, changes only in a commit cycle
//   thr_update       out  one-cycle pulse in every commit cycle
//   cfg_pending      out  pending grade differs from the committed grade
//   rpt_state[1:0]   out  auto-repeat FSM state (0 IDLE, 1 HOLD_WAIT,
//                         2 REPEAT); held at IDLE when auto-repeat is not built
// ----------------------------------------------------------------------------
module sobel_threshold_ctrl #(
   parameter int DEFAULT_GRADE = 8,
   parameter int THR_BASE      = 20,
   parameter int THR_STEP      = 5,
   parameter int HOLD_DLY      = 50_000_000,
   parameter int RPT_PERIOD    = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_flag,
   input  logic [1:0] key_value,
   input  logic       key_hold,
   input  logic       per_frame_vsync,
   output logic [3:0] sobel_grade,
   output logic [7:0] sobel_threshold,
   output logic       thr_update,
   output logic       cfg_pending,
   output logic [1:0] rpt_state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD_WAIT = 2'd1,
      REPEAT    = 2'd2
   } rpt_state_t;

   localparam logic [3:0] DEF_GRADE = 4'(DEFAULT_GRADE);

   // Threshold for a grade. The sum is truncated to 8 bits. Choosing
   // parameters that keep grade 15 in range is up to the integrator.
   function automatic logic [7:0] thr_map(input logic [3:0] g);
      thr_map = 8'(THR_BASE + THR_STEP * int'(g));
   endfunction

   logic [3:0] grade_q;
   logic [3:0] grade_nxt;
   logic [3:0] committed_q;
   logic [7:0] thr_q;
   logic       thr_upd_q;
   logic       vsync_d;
   logic       vsync_rise;
   logic       rpt_tick;

   // ------------------------------------------------------------------------
   // Auto-repeat FSM and its shared down-counter
   // ------------------------------------------------------------------------
`ifdef SOBEL_AUTO_REPEAT_EN
   localparam int CNT_MAX = (HOLD_DLY > RPT_PERIOD) ? HOLD_DLY : RPT_PERIOD;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(HOLD_DLY - 1);
   localparam logic [CNT_W-1:0] CNT_RPT  = CNT_W'(RPT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   rpt_state_t     state_q;
   rpt_state_t     state_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             key_dir;

   // Only decrement and increment can repeat. Restore never does.
   assign key_dir = (key_value == 2'b01) || (key_value == 2'b10);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      rpt_tick  = 1'b0;
      if (!key_hold || !key_dir) begin
         // Release, or a code that must not repeat, aborts immediately.
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (key_flag) begin
         // A fresh press always restarts the hold delay. The press itself is
         // the step for this cycle, so no tick is issued alongside it.
         state_nxt = HOLD_WAIT;
         cnt_nxt   = CNT_HOLD;
      end else begin
         case (state_q)
            HOLD_WAIT, REPEAT: begin
               if (cnt_q == '0) begin
                  state_nxt = REPEAT;
                  cnt_nxt   = CNT_RPT;
                  rpt_tick  = 1'b1;
               end else begin
                  cnt_nxt = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign rpt_state = state_q;
`else
   logic unused_key_hold;

   assign unused_key_hold = key_hold;
   assign rpt_tick        = 1'b0;
   assign rpt_state       = IDLE;
`endif

   // ------------------------------------------------------------------------
   // Grade stepping. A key_flag and a repeat tick in the same cycle are
   // OR-ed, so together they make a single step.
   // ------------------------------------------------------------------------
   always_comb begin
      grade_nxt = grade_q;
      if (key_flag || rpt_tick) begin
         case (key_value)
            2'b01:   if (grade_q != 4'd0)  grade_nxt = grade_q - 4'd1;
            2'b10:   if (grade_q != 4'd15) grade_nxt = grade_q + 4'd1;
            2'b11:   grade_nxt = DEF_GRADE;
            default: grade_nxt = grade_q;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Frame commit. The rise is seen one cycle after vsync goes high. On that
   // edge the threshold takes the grade already registered, so a key step in
   // the same cycle waits until the next frame.
   // ------------------------------------------------------------------------
   assign vsync_rise = per_frame_vsync && !vsync_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         grade_q     <= DEF_GRADE;
         committed_q <= DEF_GRADE;
         thr_q       <= thr_map(DEF_GRADE);
         thr_upd_q   <= 1'b0;
         vsync_d     <= 1'b0;
      end else begin
         grade_q   <= grade_nxt;
         vsync_d   <= per_frame_vsync;
         thr_upd_q <= vsync_rise;
         if (vsync_rise) begin
            thr_q       <= thr_map(grade_q);
            committed_q <= grade_q;
         end
      end
   end

   assign sobel_grade     = grade_q;
   assign sobel_threshold = thr_q;
   assign thr_update      = thr_upd_q;
   assign cfg_pending     = (grade_q != committed_q);

endmodule

// File: tb/tb_sobel_threshold_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sobel_threshold_ctrl
//
// Directed bench for sobel_threshold_ctrl with HOLD_DLY=10 and RPT_PERIOD=4.
// Expected values are worked out by hand from the threshold formula
// (20 + 5*grade) and from the repeat timing. Where auto-repeat changes the
// outcome, the expectation follows SOBEL_AUTO_REPEAT_EN.
// ----------------------------------------------------------------------------
module tb_sobel_threshold_ctrl;

   logic       clk;
   logic       rst;
   logic       key_flag;
   logic [1:0] key_value;
   logic       key_hold;
   logic       per_frame_vsync;
   logic [3:0] sobel_grade;
   logic [7:0] sobel_threshold;
   logic       thr_update;
   logic       cfg_pending;
   logic [1:0] rpt_state;

   int errors = 0;
   int checks = 0;

   sobel_threshold_ctrl #(
      .DEFAULT_GRADE (8),
      .THR_BASE      (20),
      .THR_STEP      (5),
      .HOLD_DLY      (10),
      .RPT_PERIOD    (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .key_flag        (key_flag),
      .key_value       (key_value),
      .key_hold        (key_hold),
      .per_frame_vsync (per_frame_vsync),
      .sobel_grade     (sobel_grade),
      .sobel_threshold (sobel_threshold),
      .thr_update      (thr_update),
      .cfg_pending     (cfg_pending),
      .rpt_state       (rpt_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge, then settle 1 ns past it before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Driver tasks
   task automatic press(input logic [1:0] code);
      key_flag  = 1'b1;
      key_value = code;
      step();
      key_flag  = 1'b0;
      key_value = 2'b00;
      step();
   endtask

   // One vertical blank. Counts thr_update pulses and watches that the
   // threshold only moves in a cycle that carries a pulse.
   task automatic do_frame(output int pulses, output int stray);
      logic [7:0] prev;
      pulses = 0;
      stray  = 0;
      per_frame_vsync = 1'b1;
      for (int c = 0; c < 4; c++) begin
         prev = sobel_threshold;
         step();
         if (thr_update) pulses++;
         if (sobel_threshold != prev && !thr_update) stray++;
      end
      per_frame_vsync = 1'b0;
      for (int c = 0; c < 2; c++) begin
         prev = sobel_threshold;
         step();
         if (thr_update) pulses++;
         if (sobel_threshold != prev && !thr_update) stray++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      key_flag = 1'b0;
      key_value = 2'b00;
      key_hold = 1'b0;
      per_frame_vsync = 1'b0;
      step();
      step();
      checks++; if (sobel_grade !== 4'd8) begin errors++; $display("FAIL reset_grade: got %0d expected 8", sobel_grade); end
      checks++; if (sobel_threshold !== 8'd60) begin errors++; $display("FAIL reset_thr: got %0d expected 60", sobel_threshold); end
      checks++; if (thr_update !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b expected 0", thr_update); end
      checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", cfg_pending); end
      checks++; if (rpt_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", rpt_state); end
      rst = 1'b0;
      step();
      checks++; if (thr_update !== 1'b0) begin errors++; $display("FAIL reset_release_upd: got %b expected 0", thr_update); end
   endtask

   task automatic test_frame_commit();
      int p, s;
      do_frame(p, s);
      checks++; if (p != 1) begin errors++; $display("FAIL first_frame_pulses: got %0d expected 1", p); end
      checks++; if (s != 0) begin errors++; $display("FAIL first_frame_stray: got %0d expected 0", s); end
      checks++; if (sobel_grade !== 4'd8) begin errors++; $display("FAIL first_frame_grade: got %0d expected 8", sobel_grade); end
      checks++; if (sobel_threshold !== 8'd60) begin errors++; $display("FAIL first_frame_thr: got %0d expected 60", sobel_threshold); end
   endtask

   task automatic test_pending_commit();
      int p, s;
      for (int i = 0; i < 3; i++) press(2'b10);
      checks++; if (sobel_grade !== 4'd11) begin errors++; $display("FAIL pend_grade: got %0d expected 11", sobel_grade); end
      checks++; if (sobel_threshold !== 8'd60) begin errors++; $display("FAIL pend_thr_held: got %0d expected 60", sobel_threshold); end
      checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL pend_flag_set: got %b expected 1", cfg_pending); end
      do_frame(p, s);
      checks++; if (sobel_threshold !== 8'd75) begin errors++; $display("FAIL pend_thr_commit: got %0d expected 75", sobel_threshold); end
      checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL pend_flag_clear: got %b expected 0", cfg_pending); end
      checks++; if (p != 1 || s != 0) begin errors++; $display("FAIL pend_pulses: got %0d/%0d expected 1/0", p, s); end
      // A frame with no change still pulses thr_update.
      do_frame(p, s);
      checks++; if (p != 1) begin errors++; $display("FAIL same_value_pulse: got %0d expected 1", p); end
      checks++; if (sobel_threshold !== 8'd75) begin errors++; $display("FAIL same_value_thr: got %0d expected 75", sobel_threshold); end
   endtask

   task automatic test_saturation();
      int p, s;
      for (int i = 0; i < 5; i++) press(2'b10);
      checks++; if (sobel_grade !== 4'd15) begin errors++; $display("FAIL sat_high: got %0d expected 15", sobel_grade); end
      do_frame(p, s);
      checks++; if (sobel_threshold !== 8'd95) begin errors++; $display("FAIL sat_high_thr: got %0d expected 95", sobel_threshold); end
      press(2'b00);
      checks++; if (sobel_grade !== 4'd15) begin errors++; $display("FAIL none_code: got %0d expected 15", sobel_grade); end
      press(2'b11);
      checks++; if (sobel_grade !== 4'd8) begin errors++; $display("FAIL restore: got %0d expected 8", sobel_grade); end
      for (int i = 0; i < 9; i++) press(2'b01);
      checks++; if (sobel_grade !== 4'd0) begin errors++; $display("FAIL sat_low: got %0d expected 0", sobel_grade); end
      do_frame(p, s);
      checks++; if (sobel_threshold !== 8'd20) begin errors++; $display("FAIL sat_low_thr: got %0d expected 20", sobel_threshold); end
   endtask

   task automatic test_auto_repeat();
      int first_at, second_at, n_inc;
      logic [3:0] prev;
      press(2'b10);
      press(2'b10);
      checks++; if (sobel_grade !== 4'd2) begin errors++; $display("FAIL rpt_start_grade: got %0d expected 2", sobel_grade); end
      key_flag  = 1'b1;
      key_value = 2'b10;
      key_hold  = 1'b1;
      step();
      key_flag  = 1'b0;
      checks++; if (sobel_grade !== 4'd3) begin errors++; $display("FAIL rpt_press_grade: got %0d expected 3", sobel_grade); end
`ifdef SOBEL_AUTO_REPEAT_EN
      checks++; if (rpt_state !== 2'd1) begin errors++; $display("FAIL rpt_hold_wait: got %0d expected 1", rpt_state); end
`else
      checks++; if (rpt_state !== 2'd0) begin errors++; $display("FAIL rpt_hold_wait: got %0d expected 0", rpt_state); end
`endif
      first_at  = -1;
      second_at = -1;
      n_inc     = 0;
      for (int c = 1; c <= 29; c++) begin
         prev = sobel_grade;
         step();
         if (sobel_grade != prev) begin
            n_inc++;
            if (first_at < 0) first_at = c;
            else if (second_at < 0) second_at = c;
         end
      end
      key_hold  = 1'b0;
      step();
      key_value = 2'b00;
      step();
`ifdef SOBEL_AUTO_REPEAT_EN
      checks++; if (first_at != 10) begin errors++; $display("FAIL rpt_first: got %0d expected 10", first_at); end
      checks++; if (second_at != 14) begin errors++; $display("FAIL rpt_second: got %0d expected 14", second_at); end
      checks++; if (n_inc != 5) begin errors++; $display("FAIL rpt_count: got %0d expected 5", n_inc); end
      checks++; if (sobel_grade !== 4'd8) begin errors++; $display("FAIL rpt_final: got %0d expected 8", sobel_grade); end
`else
      checks++; if (n_inc != 0) begin errors++; $display("FAIL rpt_count: got %0d expected 0", n_inc); end
      checks++; if (sobel_grade !== 4'd3) begin errors++; $display("FAIL rpt_final: got %0d expected 3", sobel_grade); end
`endif
      checks++; if (rpt_state !== 2'd0) begin errors++; $display("FAIL rpt_release_idle: got %0d expected 0", rpt_state); end
   endtask

   task automatic test_back_to_back();
      int p, s;
      press(2'b11);
      do_frame(p, s);
      checks++; if (sobel_threshold !== 8'd60) begin errors++; $display("FAIL coin_pre_thr: got %0d expected 60", sobel_threshold); end
      // Key step in the same cycle that the vsync rise is seen.
      per_frame_vsync = 1'b1;
      key_flag  = 1'b1;
      key_value = 2'b10;
      step();
      key_flag  = 1'b0;
      key_value = 2'b00;
      checks++; if (thr_update !== 1'b1) begin errors++; $display("FAIL coin_upd: got %b expected 1", thr_update); end
      checks++; if (sobel_threshold !== 8'd60) begin errors++; $display("FAIL coin_old_thr: got %0d expected 60", sobel_threshold); end
      checks++; if (sobel_grade !== 4'd9) begin errors++; $display("FAIL coin_grade: got %0d expected 9", sobel_grade); end
      checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL coin_pending: got %b expected 1", cfg_pending); end
      step();
      checks++; if (thr_update !== 1'b0) begin errors++; $display("FAIL coin_single_pulse: got %b expected 0", thr_update); end
      per_frame_vsync = 1'b0;
      step();
      step();
      do_frame(p, s);
      checks++; if (sobel_threshold !== 8'd65) begin errors++; $display("FAIL coin_next_thr: got %0d expected 65", sobel_threshold); end
      checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL coin_next_pending: got %b expected 0", cfg_pending); end
   endtask

   task automatic test_reset_mid_repeat();
      int n_change;
      for (int i = 0; i < 3; i++) press(2'b10);
      checks++; if (sobel_grade !== 4'd12) begin errors++; $display("FAIL rst_mid_start: got %0d expected 12", sobel_grade); end
      key_flag  = 1'b1;
      key_value = 2'b10;
      key_hold  = 1'b1;
      step();
      key_flag  = 1'b0;
      for (int c = 1; c <= 11; c++) step();
`ifdef SOBEL_AUTO_REPEAT_EN
      checks++; if (sobel_grade !== 4'd14 || rpt_state !== 2'd2) begin errors++; $display("FAIL rst_mid_before: got grade %0d state %0d expected 14 2", sobel_grade, rpt_state); end
`else
      checks++; if (sobel_grade !== 4'd13 || rpt_state !== 2'd0) begin errors++; $display("FAIL rst_mid_before: got grade %0d state %0d expected 13 0", sobel_grade, rpt_state); end
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (sobel_grade !== 4'd8) begin errors++; $display("FAIL rst_mid_grade: got %0d expected 8", sobel_grade); end
      checks++; if (sobel_threshold !== 8'd60) begin errors++; $display("FAIL rst_mid_thr: got %0d expected 60", sobel_threshold); end
      checks++; if (rpt_state !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", rpt_state); end
      n_change = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (sobel_grade != 4'd8 || thr_update) n_change++;
      end
      checks++; if (n_change != 0) begin errors++; $display("FAIL rst_mid_no_tick: got %0d changes expected 0", n_change); end
      checks++; if (rpt_state !== 2'd0) begin errors++; $display("FAIL rst_mid_idle: got %0d expected 0", rpt_state); end
      key_hold  = 1'b0;
      key_value = 2'b00;
      step();
   endtask

   initial begin
      test_reset();
      test_frame_commit();
      test_pending_commit();
      test_saturation();
      test_auto_repeat();
      test_back_to_back();
      test_reset_mid_repeat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
